// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC time controller: default timer width,
// byte count and the state encodings of the write and read FSMs.
package rtc_pkg;

  localparam int TIME_W_DEFAULT = 64;
  localparam int BYTES          = TIME_W_DEFAULT / 8;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_ARMED   = 2'd2,
    W_LOAD    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/rtc_snap_tx.sv
// Snapshot transmitter: captures the running time in a single cycle and
// streams it out least-significant byte first over a valid/ready interface.
module rtc_snap_tx
  import rtc_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              rd_ready,
  input  logic [TIME_W-1:0] cur_time,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              busy
);

  localparam int NBYTES = TIME_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [TIME_W-1:0] r_snap;
  logic [CNT_W-1:0]  r_rcnt;
  logic              w_take;

  assign rd_valid = (r_state == R_SEND);
  assign rd_data  = r_snap[7:0];
  assign busy     = (r_state != R_IDLE);
  assign w_take   = rd_valid & rd_ready;

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= w_next;
  end

  // Next state: a request starts a send; the last accepted byte ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      R_IDLE: if (rd_req) w_next = R_SEND;
      R_SEND: if (w_take && (r_rcnt == LAST_IDX)) w_next = R_IDLE;
      default: w_next = R_IDLE;
    endcase
  end

  // Whole-word capture keeps the snapshot atomic; shift out one byte per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
      r_rcnt <= '0;
    end else if ((r_state == R_IDLE) && rd_req) begin
      r_snap <= cur_time;
      r_rcnt <= '0;
    end else if (w_take) begin
      r_snap <= r_snap >> 8;
      r_rcnt <= r_rcnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rtc_time_ctrl.sv
// RTC time controller: collects a new time byte-wise, loads it into the
// epoch timer (optionally aligned to the next second tick) and serves
// atomic snapshots of the running time through rtc_snap_tx.
module rtc_time_ctrl
  import rtc_pkg::*;
#(
  parameter int   TIME_W     = TIME_W_DEFAULT,
  parameter logic ALIGN_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              wr_abort,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  input  logic              rd_ready,
  input  logic              one_hz,
  input  logic [TIME_W-1:0] cur_time,
  output logic              count_enable,
  output logic              load_enable,
  output logic [TIME_W-1:0] i_time,
  output logic              set_done,
  output logic              busy
);

  localparam int NBYTES = TIME_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  wr_state_e         r_wstate;
  wr_state_e         w_wnext;
  logic [CNT_W-1:0]  r_wcnt;
  logic [TIME_W-1:0] r_itime;
  logic              w_accept;
  logic              w_last;
  logic              w_abortHit;
  logic              w_rdBusy;

  assign wr_ready     = (r_wstate == W_IDLE) || (r_wstate == W_COLLECT);
  assign w_abortHit   = wr_abort && (r_wstate != W_LOAD);
  assign w_accept     = wr_valid && wr_ready && !wr_abort;
  assign w_last       = (r_wcnt == LAST_IDX);
  assign load_enable  = (r_wstate == W_LOAD);
  assign set_done     = (r_wstate == W_LOAD);
  assign count_enable = (r_wstate != W_LOAD);
  assign i_time       = r_itime;
  assign busy         = (r_wstate != W_IDLE) || w_rdBusy;

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  // Next state: the ARMED state only listens to one_hz from the cycle after the last byte.
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE, W_COLLECT: begin
        if (w_abortHit)    w_wnext = W_IDLE;
        else if (w_accept) w_wnext = w_last ? (ALIGN_LOAD ? W_ARMED : W_LOAD) : W_COLLECT;
      end
      W_ARMED: begin
        if (w_abortHit)  w_wnext = W_IDLE;
        else if (one_hz) w_wnext = W_LOAD;
      end
      W_LOAD:  w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  // Byte buffer: each accepted byte lands in its own lane of i_time, which then holds until the next set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_itime <= '0;
    end else if (w_abortHit) begin
      r_wcnt <= '0;
    end else if (w_accept) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_wcnt == CNT_W'(b)) r_itime[8*b +: 8] <= wr_data;
      end
      r_wcnt <= w_last ? '0 : (r_wcnt + CNT_W'(1));
    end
  end

  rtc_snap_tx #(
    .TIME_W (TIME_W)
  ) u_snap (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_ready (rd_ready),
    .cur_time (cur_time),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (w_rdBusy)
  );

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Testbench for rtc_time_ctrl: a table of per-cycle write vectors plus
// hand-written sequences for snapshots, load-cycle snapshots and reset.
module tb_rtc_time_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrValid = 1'b0;
  logic [7:0]  wrData = 8'h00;
  logic        wrAbort = 1'b0;
  logic        rdReq = 1'b0;
  logic        rdReady = 1'b0;
  logic        oneHz = 1'b0;
  logic [63:0] timeVal = 64'd0;

  logic        wrReady, rdValid, countEnable, loadEnable, setDone, busy;
  logic [7:0]  rdData;
  logic [63:0] iTime;

  logic        wrReady0, rdValid0, countEnable0, loadEnable0, setDone0, busy0;
  logic [7:0]  rdData0;
  logic [63:0] iTime0;

  int checkCount = 0;
  int errCount = 0;
  int loadPulses0 = 0;

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        ab;
    logic        hz;
    logic        expReady;
    logic        expLoad;
    logic        chk;
    logic [63:0] expItime;
    logic [63:0] expTime;
  } vec_t;

  vec_t vecs[$];

  rtc_time_ctrl #(.TIME_W(64), .ALIGN_LOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wrValid), .wr_data(wrData), .wr_ready(wrReady),
    .wr_abort(wrAbort), .rd_req(rdReq), .rd_valid(rdValid), .rd_data(rdData),
    .rd_ready(rdReady), .one_hz(oneHz), .cur_time(timeVal), .count_enable(countEnable),
    .load_enable(loadEnable), .i_time(iTime), .set_done(setDone), .busy(busy)
  );

  rtc_time_ctrl #(.TIME_W(64), .ALIGN_LOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(wrValid), .wr_data(wrData), .wr_ready(wrReady0),
    .wr_abort(wrAbort), .rd_req(rdReq), .rd_valid(rdValid0), .rd_data(rdData0),
    .rd_ready(rdReady), .one_hz(oneHz), .cur_time(timeVal), .count_enable(countEnable0),
    .load_enable(loadEnable0), .i_time(iTime0), .set_done(setDone0), .busy(busy0)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural epoch timer fed by the aligned controller.
  always @(posedge clk) begin
    if (loadEnable)                timeVal <= iTime;
    else if (countEnable && oneHz) timeVal <= timeVal + 64'd1;
  end

  // Count load pulses from the unaligned controller for the reset scenario.
  always @(negedge clk) begin
    if (loadEnable0) loadPulses0++;
  end

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic ab,
                               input logic hz, input logic rq, input logic rr);
    @(negedge clk);
    wrValid = wv;
    wrData  = wd;
    wrAbort = ab;
    oneHz   = hz;
    rdReq   = rq;
    rdReady = rr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addRow(input logic wv, input logic [7:0] wd, input logic ab,
                        input logic hz, input logic rdy, input logic ld);
    vec_t v;
    v.wv = wv; v.wd = wd; v.ab = ab; v.hz = hz;
    v.expReady = rdy; v.expLoad = ld;
    v.chk = 1'b0; v.expItime = 64'd0; v.expTime = 64'd0;
    vecs.push_back(v);
  endtask

  task automatic addChk(input logic rdy, input logic [63:0] it, input logic [63:0] tv);
    vec_t v;
    v.wv = 1'b0; v.wd = 8'h00; v.ab = 1'b0; v.hz = 1'b0;
    v.expReady = rdy; v.expLoad = 1'b0;
    v.chk = 1'b1; v.expItime = it; v.expTime = tv;
    vecs.push_back(v);
  endtask

  task automatic readBytes(input logic [63:0] exp, input string tag);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("%s valid%0d", tag, k), {63'd0, rdValid}, 64'd1);
      checkOutput($sformatf("%s byte%0d", tag, k), {56'd0, rdData}, {56'd0, exp[8*k +: 8]});
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput($sformatf("%s valid_end", tag), {63'd0, rdValid}, 64'd0);
  endtask

  initial begin
    // Basic aligned set 0x0102030405060708, tick 20 cycles later, then one more tick.
    for (int k = 0; k < 8; k++) addRow(1'b1, 8'(8 - k), 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    addChk(1'b1, 64'h0102030405060708, 64'h0102030405060708);
    addRow(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    addChk(1'b1, 64'h0102030405060708, 64'h0102030405060709);
    // Coincident tick on the last byte does not trigger the load.
    for (int k = 0; k < 7; k++) addRow(1'b1, 8'(16 + k), 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'h17, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    addChk(1'b1, 64'h1716151413121110, 64'h1716151413121110);
    // Abort with a coincident 6th byte, then a fresh set of 0xDEADBEEF.
    for (int k = 0; k < 5; k++) addRow(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'hBE, 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) addRow(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    addChk(1'b1, 64'h00000000DEADBEEF, 64'h00000000DEADBEEF);

    // Reset state, checked while reset is held.
    #1 rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst wr_ready", {63'd0, wrReady}, 64'd1);
    checkOutput("rst load_enable", {63'd0, loadEnable}, 64'd0);
    checkOutput("rst count_enable", {63'd0, countEnable}, 64'd1);
    checkOutput("rst set_done", {63'd0, setDone}, 64'd0);
    checkOutput("rst rd_valid", {63'd0, rdValid}, 64'd0);
    checkOutput("rst rd_data", {56'd0, rdData}, 64'd0);
    checkOutput("rst i_time", iTime, 64'd0);
    checkOutput("rst busy", {63'd0, busy}, 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset in the middle of a set on the unaligned controller.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid i_time", iTime0, 64'h0000000000CCBBAA);
    checkOutput("mid busy", {63'd0, busy0}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid rst i_time", iTime0, 64'd0);
    checkOutput("mid rst busy", {63'd0, busy0}, 64'd0);
    checkOutput("mid rst wr_ready", {63'd0, wrReady0}, 64'd1);
    checkOutput("mid rst count_enable", {63'd0, countEnable0}, 64'd1);
    checkOutput("mid rst load_enable", {63'd0, loadEnable0}, 64'd0);
    checkOutput("mid rst set_done", {63'd0, setDone0}, 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid load pulses", 64'(loadPulses0), 64'd0);
    checkOutput("mid post i_time", iTime0, 64'h0000002211FFEEDD);
    checkOutput("mid post wr_ready", {63'd0, wrReady0}, 64'd1);
    checkOutput("mid post busy", {63'd0, busy0}, 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Table-driven write scenarios on the aligned controller.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].ab, vecs[i].hz, 1'b0, 1'b0);
      checkOutput($sformatf("row%0d wr_ready", i), {63'd0, wrReady}, {63'd0, vecs[i].expReady});
      checkOutput($sformatf("row%0d load_enable", i), {63'd0, loadEnable}, {63'd0, vecs[i].expLoad});
      checkOutput($sformatf("row%0d count_enable", i), {63'd0, countEnable}, {63'd0, !vecs[i].expLoad});
      checkOutput($sformatf("row%0d set_done", i), {63'd0, setDone}, {63'd0, vecs[i].expLoad});
      if (vecs[i].chk) begin
        checkOutput($sformatf("row%0d i_time", i), iTime, vecs[i].expItime);
        checkOutput($sformatf("row%0d timer", i), timeVal, vecs[i].expTime);
      end
    end

    // Snapshot of 0xDEADBEEF with a 5-cycle stall and an ignored second request.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("snap req rd_valid", {63'd0, rdValid}, 64'd0);
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, (s == 2), 1'b0);
      checkOutput($sformatf("stall%0d rd_valid", s), {63'd0, rdValid}, 64'd1);
      checkOutput($sformatf("stall%0d rd_data", s), {56'd0, rdData}, 64'hEF);
    end
    readBytes(64'h00000000DEADBEEF, "snap");
    checkOutput("snap busy_end", {63'd0, busy}, 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("snap no_requeue", {63'd0, rdValid}, 64'd0);

    // Snapshot requested in the load cycle sees the pre-load time.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ldsnap load_enable", {63'd0, loadEnable}, 64'd1);
    readBytes(64'h00000000DEADBEF0, "ldsnap pre");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    readBytes(64'h0A0B0C0D0E0F1011, "ldsnap post");

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rtc_time_ctrl.md
Name: rtc_time_ctrl

Overview:
- Controller that sequences the 64-bit epoch timer for the host.
- Accepts a new time as an 8-byte stream, buffers it, and drives the timer's load port aligned to the divider's one_hz pulse.
- Takes atomic 64-bit snapshots of the running time and streams them back as 8 bytes.
- Sits between the host byte interface and the divider/timer pair, and owns the timer's count_enable, load_enable and i_time inputs.

Parameters:
- TIME_W, 64, timer width; must be a multiple of 8.
- ALIGN_LOAD, 1: when 1, the load waits for the next one_hz pulse; when 0, the load happens in the cycle after the last byte is accepted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  set-time byte valid
- wr_data  in  8  set-time byte, least-significant byte first
- wr_ready  out  1  controller can accept a byte
- wr_abort  in  1  discard a partial or armed set
- rd_req  in  1  single-cycle snapshot request
- rd_valid  out  1  snapshot byte valid
- rd_data  out  8  snapshot byte, least-significant byte first
- rd_ready  in  1  host accepts snapshot byte
- one_hz  in  1  single-cycle second tick from the divider
- cur_time  in  TIME_W  timer o_time
- count_enable  out  1  to timer
- load_enable  out  1  to timer
- i_time  out  TIME_W  to timer
- set_done  out  1  single-cycle pulse, asserted in the load cycle
- busy  out  1  high whenever either FSM is not idle

Behaviour:
- Reset (async, rst=1): write FSM goes to W_IDLE; read FSM goes to R_IDLE; byte counters = 0; i_time = 0; load_enable = 0; set_done = 0; count_enable = 1; rd_valid = 0; rd_data = 0.
- wr_ready is combinational: 1 in W_IDLE and W_COLLECT, 0 in W_ARMED and W_LOAD. It is therefore 1 from the first cycle after reset.
- Write FSM:
  - W_IDLE: an accepted byte (wr_valid & wr_ready) goes to i_time[7:0]; wcnt = 1; next state W_COLLECT.
  - W_COLLECT: each accepted byte goes to i_time[8*wcnt +: 8] and wcnt increments. The byte that completes TIME_W/8 bytes moves to W_ARMED if ALIGN_LOAD=1, otherwise to W_LOAD. No bytes are accepted in W_ARMED or W_LOAD.
  - W_ARMED: holds until one_hz=1, then moves to W_LOAD. If one_hz is high in the same cycle the last byte is accepted, that pulse does not count; the FSM waits for the following pulse.
  - W_LOAD: lasts exactly one cycle, with load_enable=1, count_enable=0 and set_done=1; then returns to W_IDLE.
  - In every other cycle, count_enable=1 and load_enable=0.
- Load timing: with ALIGN_LOAD=1, the load cycle is the cycle after the one_hz-seen cycle. Within 1 clk after the second boundary, the timer holds exactly the written value. The second tick at that boundary is intentionally suppressed and is replaced by the loaded value.
- i_time is registered and stable from the last byte through the load cycle. It holds its value after the load.
- wr_abort:
  - In any state other than W_LOAD: return to W_IDLE, wcnt=0, no load. If abort coincides with an accepted byte, abort wins and the byte is dropped.
  - In W_LOAD: ignored; the load completes.
- Read FSM:
  - R_IDLE: rd_req=1 captures cur_time into a TIME_W shift register in that cycle; rcnt = 0; next state R_SEND.
  - R_SEND: rd_valid=1 and rd_data = snap[7:0] (registered, valid the cycle after the capture). On rd_valid & rd_ready, shift snap right by 8 and increment rcnt. After the final byte is accepted, rd_valid drops in the next cycle and the FSM returns to R_IDLE.
  - rd_data and rd_valid stay stable while rd_ready=0.
  - rd_req is ignored outside R_IDLE (no queueing).
- Snapshot atomicity: all 64 bits come from a single cycle's cur_time. A snapshot taken in the load cycle captures the pre-load value, because cur_time is the timer's registered output.
- The write and read FSMs are independent and may run concurrently.
- rst asserted mid-operation aborts both FSMs immediately. A partial set is lost, and no load_enable pulse is emitted.

Decomposition:
- Shared package rtc_pkg holds:
  - TIME_W default
  - BYTES = TIME_W/8
  - write-FSM state encoding: W_IDLE, W_COLLECT, W_ARMED, W_LOAD
  - read-FSM state encoding: R_IDLE, R_SEND
- One natural sub-module: rtc_snap_tx, the read FSM plus snapshot shift register and valid/ready byte output.
- The write FSM and load sequencing stay in the top module.

Test Plan:
- Basic aligned set: ALIGN_LOAD=1; send bytes 0x08,0x07,...,0x01 (value 0x0102030405060708) back-to-back; one_hz 20 cycles later. Required: wr_ready=0 after the 8th byte; load_enable=1, count_enable=0 and set_done=1 for exactly 1 cycle, one cycle after one_hz; i_time=0x0102030405060708; timer o_time equals that value and increments on the next one_hz.
- Coincident tick: one_hz high in the same cycle the 8th byte is accepted. Required: no load on that tick; the load follows the next one_hz.
- Abort: send 5 bytes, assert wr_abort together with a 6th byte. Required: no load_enable; wr_ready=1 the next cycle. A fresh 8-byte set afterwards loads the new value correctly.
- Snapshot with backpressure: timer at 0x00000000DEADBEEF; pulse rd_req; hold rd_ready=0 for 5 cycles, then 1. Required: rd_data sequence EF,BE,AD,DE,00,00,00,00; data stable during the stall; rd_valid=0 after the 8th byte; a second rd_req during R_SEND is ignored.
- Snapshot in the load cycle: rd_req coincides with load_enable. Required: the snapshot equals the pre-load time; the subsequent read returns the new value.
- Reset mid-set: ALIGN_LOAD=0; assert rst after 3 bytes. Required: outputs take their reset values immediately; count_enable=1; no load_enable pulse.
